// File: rtl/bus_pkg.sv
// Shared types and encodings for the 8085 bus-cycle sequencer.
// Cycle codes, T-state names and the status pins driven for each cycle type.
package bus_pkg;

    typedef enum logic [2:0] {
        OF  = 3'b000,
        MR  = 3'b001,
        MW  = 3'b010,
        IOR = 3'b011,
        IOW = 3'b100,
        INA = 3'b101
    } cycle_t;

    typedef enum logic [2:0] {TI, T1, T2, TW, T3, T4, TH} tstate_t;

    // Status encodings, packed as {IOMn, S1, S0}
    localparam logic [2:0] STAT_IDLE = 3'b000;
    localparam logic [2:0] STAT_OF   = 3'b011;
    localparam logic [2:0] STAT_MR   = 3'b010;
    localparam logic [2:0] STAT_MW   = 3'b001;
    localparam logic [2:0] STAT_IOR  = 3'b110;
    localparam logic [2:0] STAT_IOW  = 3'b101;
    localparam logic [2:0] STAT_INA  = 3'b111;

    function automatic logic is_legal(input logic [2:0] code);
        return code <= 3'd5;
    endfunction

    function automatic logic [2:0] status_of(input cycle_t t);
        case (t)
            OF:      return STAT_OF;
            MR:      return STAT_MR;
            MW:      return STAT_MW;
            IOR:     return STAT_IOR;
            IOW:     return STAT_IOW;
            INA:     return STAT_INA;
            default: return STAT_IDLE;
        endcase
    endfunction

    function automatic logic is_read(input cycle_t t);
        return (t == OF) || (t == MR) || (t == IOR);
    endfunction

    function automatic logic is_write(input cycle_t t);
        return (t == MW) || (t == IOW);
    endfunction

    function automatic logic has_t4(input cycle_t t);
        return (t == OF) || (t == INA);
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// 8085 machine-cycle sequencer: runs one decoded bus request as T1/T2/TW/T3[/T4]
// and drives the pad-level strobes, status, AD enables and the HOLD/HLDA grant.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned WCNT_W      = 4
) (
    input  logic        phi1,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  cycle_type,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        ready,
    input  logic        hold,
    input  logic [7:0]  ad_in,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [7:0]  haddress,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        INTAn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    output logic        hlda,
    output logic        bus_float
);

    tstate_t           state, state_nxt;
    cycle_t            typ_q, typ_nxt;
    logic [15:0]       addr_q, addr_nxt;
    logic [7:0]        wdata_q, wdata_nxt;
    logic [WCNT_W-1:0] wcnt_q, wcnt_nxt;
    logic              accept, reject;
    logic              strobe_nxt, busy_nxt;

    always_comb begin
        state_nxt = state;
        typ_nxt   = typ_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        wcnt_nxt  = wcnt_q;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            TI: begin
                if (hold) begin
                    state_nxt = TH;
                end else if (req) begin
                    if (is_legal(cycle_type)) begin
                        accept    = 1'b1;
                        state_nxt = T1;
                        typ_nxt   = cycle_t'(cycle_type);
                        addr_nxt  = addr;
                        wdata_nxt = wdata;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            T1: begin
                state_nxt = T2;
                wcnt_nxt  = WCNT_W'(WAIT_STATES);
            end
            // Forced wait states run out before READY is looked at
            T2, TW: begin
                if (wcnt_q != '0) begin
                    state_nxt = TW;
                    wcnt_nxt  = wcnt_q - WCNT_W'(1);
                end else if (!ready) begin
                    state_nxt = TW;
                end else begin
                    state_nxt = T3;
                end
            end
            T3:      state_nxt = has_t4(typ_q) ? T4 : TI;
            T4:      state_nxt = TI;
            TH:      if (!hold) state_nxt = TI;
            default: state_nxt = TI;
        endcase
        strobe_nxt = (state_nxt == T2) || (state_nxt == TW) || (state_nxt == T3);
        busy_nxt   = strobe_nxt || (state_nxt == T1) || (state_nxt == T4);
    end

    // Accept and reject are visible in the same TI cycle the request is presented
    assign ack      = accept & ~rst;
    assign err      = reject & ~rst;
    assign haddress = addr_q[15:8];

    // Pin outputs are registered from the next-state decode so they line up with state
    always_ff @(posedge phi1) begin
        if (rst) begin
            state          <= TI;
            typ_q          <= OF;
            addr_q         <= '0;
            wdata_q        <= '0;
            wcnt_q         <= '0;
            rdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ALE            <= 1'b0;
            RDn            <= 1'b1;
            WRn            <= 1'b1;
            INTAn          <= 1'b1;
            {IOMn, S1, S0} <= STAT_IDLE;
            ad_oe          <= 1'b0;
            ad_out         <= '0;
            hlda           <= 1'b0;
            bus_float      <= 1'b0;
        end else begin
            state   <= state_nxt;
            typ_q   <= typ_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            wcnt_q  <= wcnt_nxt;

            if (state == T3 && (is_read(typ_q) || typ_q == INA))
                rdata <= ad_in;

            done  <= (state == T4) || (state == T3 && !has_t4(typ_q));
            busy  <= busy_nxt;
            ALE   <= (state_nxt == T1);
            RDn   <= !(strobe_nxt && is_read(typ_nxt));
            WRn   <= !(strobe_nxt && is_write(typ_nxt));
            INTAn <= !(strobe_nxt && typ_nxt == INA);
            {IOMn, S1, S0} <= busy_nxt ? status_of(typ_nxt) : STAT_IDLE;

            ad_oe <= (state_nxt == T1) || (strobe_nxt && is_write(typ_nxt));
            if (state_nxt == T1)
                ad_out <= addr_nxt[7:0];
            else if (strobe_nxt && is_write(typ_nxt))
                ad_out <= wdata_nxt;
            else
                ad_out <= '0;

            hlda      <= (state_nxt == TH);
            bus_float <= (state_nxt == TH);
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed scenarios plus randomized
// transactions against a transaction-level timing model, for WAIT_STATES 0 and 2.
module tb_bus_cycle_ctrl;

    logic        phi1 = 1'b0;
    logic        rst, req, ready, hold;
    logic [2:0]  cyc_type;
    logic [15:0] addr;
    logic [7:0]  wdata, ad_in;

    logic       ack_w [2], busy_w [2], done_w [2], err_w [2], ale_w [2], rdn_w [2], wrn_w [2];
    logic       intan_w [2], iomn_w [2], s1_w [2], s0_w [2], oe_w [2], hlda_w [2], fl_w [2];
    logic [7:0] rdata_w [2], hadr_w [2], adout_w [2];

    int         sel, ws, total, bad;
    logic [7:0] model_rdata;

    always #5 phi1 = ~phi1;

    bus_cycle_ctrl #(.WAIT_STATES(0), .WCNT_W(4)) u_ws0 (
        .phi1(phi1), .rst(rst), .req(req), .cycle_type(cyc_type), .addr(addr),
        .wdata(wdata), .ready(ready), .hold(hold), .ad_in(ad_in),
        .ack(ack_w[0]), .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
        .err(err_w[0]), .haddress(hadr_w[0]), .ad_out(adout_w[0]), .ad_oe(oe_w[0]),
        .ALE(ale_w[0]), .RDn(rdn_w[0]), .WRn(wrn_w[0]), .INTAn(intan_w[0]),
        .IOMn(iomn_w[0]), .S1(s1_w[0]), .S0(s0_w[0]), .hlda(hlda_w[0]), .bus_float(fl_w[0])
    );

    bus_cycle_ctrl #(.WAIT_STATES(2), .WCNT_W(4)) u_ws2 (
        .phi1(phi1), .rst(rst), .req(req), .cycle_type(cyc_type), .addr(addr),
        .wdata(wdata), .ready(ready), .hold(hold), .ad_in(ad_in),
        .ack(ack_w[1]), .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
        .err(err_w[1]), .haddress(hadr_w[1]), .ad_out(adout_w[1]), .ad_oe(oe_w[1]),
        .ALE(ale_w[1]), .RDn(rdn_w[1]), .WRn(wrn_w[1]), .INTAn(intan_w[1]),
        .IOMn(iomn_w[1]), .S1(s1_w[1]), .S0(s0_w[1]), .hlda(hlda_w[1]), .bus_float(fl_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle-type properties straight from the 8085 bus tables
    function automatic logic [2:0] stat_of(input int t);
        case (t)
            0:       return 3'b011;
            1:       return 3'b010;
            2:       return 3'b001;
            3:       return 3'b110;
            4:       return 3'b101;
            default: return 3'b111;
        endcase
    endfunction
    function automatic bit rd_type(input int t); return t == 0 || t == 1 || t == 3; endfunction
    function automatic bit wr_type(input int t); return t == 2 || t == 4; endfunction
    function automatic bit t4_type(input int t); return t == 0 || t == 5; endfunction

    function automatic logic [27:0] vec(input logic b, d, al, rd, wr, ia, input logic [2:0] st,
                                        input logic oe, hl, fl, input logic [7:0] ad, ha);
        return {b, d, al, rd, wr, ia, st, oe, hl, fl, ad, ha};
    endfunction

    function automatic logic [27:0] obs();
        return vec(busy_w[sel], done_w[sel], ale_w[sel], rdn_w[sel], wrn_w[sel], intan_w[sel],
                   {iomn_w[sel], s1_w[sel], s0_w[sel]}, oe_w[sel], hlda_w[sel], fl_w[sel],
                   oe_w[sel] ? adout_w[sel] : 8'h00, busy_w[sel] ? hadr_w[sel] : 8'h00);
    endfunction

    function automatic logic [27:0] idle_vec();
        return vec(0, 0, 0, 1, 1, 1, 3'b000, 0, 0, 0, 8'h00, 8'h00);
    endfunction
    function automatic logic [27:0] th_vec();
        return vec(0, 0, 0, 1, 1, 1, 3'b000, 0, 1, 1, 8'h00, 8'h00);
    endfunction

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    // Starts in the current (TI) cycle and ends in the done cycle. Wait states are
    // max(WAIT_STATES, k) since ready is low for the first k cycles from T2.
    task automatic do_xact(input int t, input logic [15:0] a, input logic [7:0] wd, di,
                           input int k, input int hold_at, input int rst_at, input bit b2b);
        int waits, len;
        bit strobe, bsy, oe;
        logic [7:0] ad;
        waits = (ws > k) ? ws : k;
        len   = 4 + waits + (t4_type(t) ? 1 : 0);
        req = 1'b1; cyc_type = 3'(t); addr = a; wdata = wd; ad_in = di; ready = 1'b1;
        #1;
        check("ack", ack_w[sel], 1);
        check("no_err", err_w[sel], 0);
        if (b2b) check("b2b_done", done_w[sel], 1);
        for (int c = 1; c <= len; c++) begin
            step();
            req   = 1'b0;
            ready = !(c >= 2 && c < 2 + k);
            if (c == hold_at) hold = 1'b1;
            if (c == rst_at + 1) begin
                rst = 1'b0;
                model_rdata = 8'h00;
                check("rst_vec", obs(), idle_vec());
                check("rst_rdata", rdata_w[sel], model_rdata);
                return;
            end
            if (c == rst_at) rst = 1'b1;
            strobe = (c >= 2) && (c <= 3 + waits);
            bsy    = c < len;
            oe     = (c == 1) || (strobe && wr_type(t));
            ad     = (c == 1) ? a[7:0] : (oe ? wd : 8'h00);
            check($sformatf("t%0d_c%0d", t, c), obs(),
                  vec(bsy, c == len, c == 1, !(strobe && rd_type(t)), !(strobe && wr_type(t)),
                      !(strobe && t == 5), bsy ? stat_of(t) : 3'b000, oe, 0, 0, ad,
                      bsy ? a[15:8] : 8'h00));
            if (c == len) begin
                if (rd_type(t) || t == 5) model_rdata = di;
                check("rdata", rdata_w[sel], model_rdata);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            req = 1'b0;
            check("idle", obs(), idle_vec());
        end
    endtask

    // Ends in the first TI cycle after release, where a pending request is already acked
    task automatic hold_phase(input int n, input bit with_req);
        hold = 1'b1; req = with_req; cyc_type = 3'd1; addr = 16'h0000;
        #1;
        check("hold_noack", ack_w[sel], 0);
        for (int i = 0; i < n; i++) begin
            step();
            if (i == n - 1) hold = 1'b0;
            #1;
            check("th_vec", obs(), th_vec());
            check("th_noack", ack_w[sel], 0);
        end
        step();
        check("hold_rel", obs(), idle_vec());
        check("rel_ack", ack_w[sel], with_req);
    endtask

    task automatic bad_req(input int n, input logic [2:0] code);
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            req = 1'b1; cyc_type = code;
            #1;
            check("err", err_w[sel], 1);
            check("bad_noack", ack_w[sel], 0);
            if (i > 0) check("bad_idle", obs(), idle_vec());
        end
        step();
        req = 1'b0;
        #1;
        check("err_clr", err_w[sel], 0);
        check("bad_after", obs(), idle_vec());
    endtask

    task automatic rand_block(input int n);
        for (int i = 0; i < n; i++) begin
            int t, k, r;
            t = $urandom_range(0, 5);
            k = $urandom_range(0, 3);
            r = $urandom_range(0, 7);
            if (r == 0) hold_phase($urandom_range(1, 3), 1'b1);
            else if (r == 1) bad_req($urandom_range(1, 2), 3'b110 + 3'($urandom_range(0, 1)));
            do_xact(t, 16'($urandom), 8'($urandom), 8'($urandom), k, -1, -10, 1'b0);
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic reset_both();
        rst = 1'b1; req = 1'b0; hold = 1'b0; ready = 1'b1;
        step();
        model_rdata = 8'h00;
        check("reset_vec", obs(), idle_vec());
        check("reset_rdata", rdata_w[sel], model_rdata);
        check("reset_ack", ack_w[sel], 0);
        check("reset_err", err_w[sel], 0);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; sel = 0; ws = 0;
        rst = 1'b1; req = 1'b0; ready = 1'b1; hold = 1'b0;
        cyc_type = 3'd0; addr = 16'h0000; wdata = 8'h00; ad_in = 8'h00; model_rdata = 8'h00;
        step();
        reset_both();
        step();

        do_xact(1, 16'h1234, 8'h00, 8'h5A, 0, -1, -10, 1'b0);
        idle(1);
        do_xact(2, 16'h8001, 8'hC3, 8'h77, 2, -1, -10, 1'b0);
        idle(1);
        do_xact(0, 16'h0100, 8'h00, 8'h3E, 0, -1, -10, 1'b0);
        do_xact(3, 16'h0042, 8'h00, 8'h81, 0, -1, -10, 1'b1);
        do_xact(1, 16'hA55A, 8'h00, 8'h19, 0, 2, -10, 1'b0);
        hold_phase(3, 1'b1);
        do_xact(4, 16'h00F0, 8'h6D, 8'h00, 1, -1, -10, 1'b0);
        idle(1);
        do_xact(2, 16'h4000, 8'hEE, 8'h00, 5, -1, 3, 1'b0);
        idle(3);
        bad_req(3, 3'b111);
        bad_req(1, 3'b110);
        do_xact(5, 16'h0038, 8'h00, 8'hFF, 0, -1, -10, 1'b0);
        rand_block(30);

        sel = 1; ws = 2;
        reset_both();
        do_xact(0, 16'h2000, 8'h00, 8'hA1, 0, -1, -10, 1'b0);
        do_xact(3, 16'h0011, 8'h00, 8'hB2, 0, -1, -10, 1'b1);
        idle(1);
        do_xact(2, 16'h8001, 8'hC3, 8'h00, 1, -1, -10, 1'b0);
        do_xact(1, 16'h5555, 8'h00, 8'h4C, 4, -1, -10, 1'b1);
        rand_block(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
